// File: rtl/seq_stream_checker_if.sv
// Stream-checker bus: monitored sample/control inputs and registered status outputs.
// The checker attaches through the slave modport; the driving side uses master.
interface seq_stream_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             locked;
  logic             fail;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] last_bad;
  logic [1:0]       state;

  modport master (
    output en, clr, d,
    input  locked, fail, good_cnt, err_cnt, last_bad, state
  );

  modport slave (
    input  en, clr, d,
    output locked, fail, good_cnt, err_cnt, last_bad, state
  );

endinterface

// File: rtl/seq_stream_checker.sv
// Sequence checker for a stepping data stream: verifies that each enabled sample
// advances by STEP (mod 2^WIDTH), counts good/bad samples, reports lock and a
// sticky failure once ERR_LIMIT mismatches have been seen.
// Optional macro SEQ_STREAM_CHECKER_HOLD_EN: a repeat of the previous accepted
// value in TRACK is tolerated as a stall instead of counting as a mismatch.
module seq_stream_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned STEP      = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned LOCK_N    = 2
) (
  input logic                clk,
  input logic                rst,
  seq_stream_checker_if.slave bus
);

`ifdef SEQ_STREAM_CHECKER_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  localparam int unsigned    RunW     = $clog2(LOCK_N + 1);
  localparam logic [WIDTH-1:0] StepC    = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] ErrLimC  = CNT_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [RunW-1:0]  LockNC   = RunW'(LOCK_N);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StTrack   = 2'd2,
    StFail    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] last_bad_q, last_bad_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  // Next-state: clear beats enable; nothing moves while en is low.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    run_d      = run_q;
    good_d     = good_q;
    err_d      = err_q;
    last_bad_d = last_bad_q;
    locked_d   = locked_q;
    fail_d     = fail_q;

    if (bus.clr) begin
      state_d    = StIdle;
      exp_d      = '0;
      run_d      = '0;
      good_d     = '0;
      err_d      = '0;
      last_bad_d = '0;
      locked_d   = 1'b0;
      fail_d     = 1'b0;
    end else if (bus.en) begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcquire;
        end
        StAcquire: begin
          exp_d    = bus.d + StepC;
          run_d    = '0;
          locked_d = 1'b0;
          state_d  = StTrack;
        end
        StTrack: begin
          if (bus.d == exp_q) begin
            if (good_q != CntMax) good_d = good_q + 1'b1;
            if (run_q != LockNC) run_d = run_q + 1'b1;
            locked_d = (run_d == LockNC);
            exp_d    = bus.d + StepC;
          end else if (HoldEn && (bus.d == exp_q - StepC)) begin
            // Upstream stall: repeat of the last accepted value, leave everything alone.
            exp_d = exp_q;
          end else begin
            if (err_q != CntMax) err_d = err_q + 1'b1;
            last_bad_d = bus.d;
            run_d      = '0;
            locked_d   = 1'b0;
            exp_d      = bus.d + StepC;  // resync to the new value
            if (err_d >= ErrLimC) begin
              state_d = StFail;
              fail_d  = 1'b1;
            end
          end
        end
        StFail: begin
          locked_d = 1'b0;
          fail_d   = 1'b1;
        end
      endcase
    end
  end

  // State and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      run_q      <= '0;
      good_q     <= '0;
      err_q      <= '0;
      last_bad_q <= '0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      good_q     <= good_d;
      err_q      <= err_d;
      last_bad_q <= last_bad_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.locked   = locked_q;
  assign bus.fail     = fail_q;
  assign bus.good_cnt = good_q;
  assign bus.err_cnt  = err_q;
  assign bus.last_bad = last_bad_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed and randomized bench for seq_stream_checker against a value-history model.
module tb_seq_stream_checker;

  localparam int WIDTH     = 4;
  localparam int STEP      = 1;
  localparam int CNT_W     = 16;
  localparam int ERR_LIMIT = 3;
  localparam int LOCK_N    = 2;
  localparam int MOD       = 1 << WIDTH;
  localparam int CMAX      = (1 << CNT_W) - 1;

`ifdef SEQ_STREAM_CHECKER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic rst;

  seq_stream_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_stream_checker #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .CNT_W    (CNT_W),
    .ERR_LIMIT(ERR_LIMIT),
    .LOCK_N   (LOCK_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=idle,1=acquire,2=track,3=fail; prev = last accepted value.
  int m_mode, m_prev, m_run, m_good, m_err, m_bad;

  function automatic void model_reset();
    m_mode = 0; m_prev = (MOD - STEP) % MOD; m_run = 0;
    m_good = 0; m_err = 0; m_bad = 0;
  endfunction

  function automatic void model(input bit e, input bit c, input int dv);
    if (c) begin
      model_reset();
    end else if (e) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        m_prev = dv; m_run = 0; m_mode = 2;
      end else if (m_mode == 2) begin
        if (dv == (m_prev + STEP) % MOD) begin
          m_good = (m_good < CMAX) ? m_good + 1 : m_good;
          m_run  = (m_run < LOCK_N) ? m_run + 1 : m_run;
          m_prev = dv;
        end else if (HOLD && dv == m_prev) begin
          // stall tolerated
        end else begin
          m_err = (m_err < CMAX) ? m_err + 1 : m_err;
          m_bad = dv; m_run = 0; m_prev = dv;
          if (m_err >= ERR_LIMIT) m_mode = 3;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},    32'(bus.state),    32'(m_mode));
    check({tag, ".locked"},   32'(bus.locked),   32'(m_mode == 2 && m_run >= LOCK_N));
    check({tag, ".fail"},     32'(bus.fail),     32'(m_mode == 3));
    check({tag, ".good_cnt"}, 32'(bus.good_cnt), 32'(m_good));
    check({tag, ".err_cnt"},  32'(bus.err_cnt),  32'(m_err));
    check({tag, ".last_bad"}, 32'(bus.last_bad), 32'(m_bad));
  endtask

  task automatic step(input bit e, input bit c, input int dv);
    bus.en  = e;
    bus.clr = c;
    bus.d   = WIDTH'(dv);
    @(posedge clk);
    model(e, c, dv);
    #1;
    check_all("step");
  endtask

  // Clear, then one enabled idle cycle so the next sample is the acquire sample.
  task automatic restart();
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 0);
  endtask

  initial begin
    int prev_d;
    int r;
    bus.en = 1'b0; bus.clr = 1'b0; bus.d = '0;
    model_reset();

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    check_all("reset");
    check("reset.state", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1;
    check_all("reset_held");
    #3 rst = 1'b1;

    // Plain count 0..9
    step(1'b1, 1'b0, 0);
    for (int i = 0; i <= 9; i++) begin
      step(1'b1, 1'b0, i);
      if (i == 1) check("count.locked_at1", 32'(bus.locked), 32'd0);
      if (i == 2) check("count.locked_at2", 32'(bus.locked), 32'd1);
    end
    check("count.good", 32'(bus.good_cnt), 32'd9);
    check("count.err", 32'(bus.err_cnt), 32'd0);
    check("count.state", 32'(bus.state), 32'd2);

    // Wrap-around 13,14,15,0,1
    restart();
    step(1'b1, 1'b0, 13); step(1'b1, 1'b0, 14); step(1'b1, 1'b0, 15);
    step(1'b1, 1'b0, 0);  step(1'b1, 1'b0, 1);
    check("wrap.good", 32'(bus.good_cnt), 32'd4);
    check("wrap.err", 32'(bus.err_cnt), 32'd0);

    // Single jump with resync: 0,1,2,7,8,9
    restart();
    step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 1); step(1'b1, 1'b0, 2);
    step(1'b1, 1'b0, 7);
    check("jump.locked_drop", 32'(bus.locked), 32'd0);
    step(1'b1, 1'b0, 8);
    check("jump.locked_at8", 32'(bus.locked), 32'd0);
    step(1'b1, 1'b0, 9);
    check("jump.locked_back", 32'(bus.locked), 32'd1);
    check("jump.err", 32'(bus.err_cnt), 32'd1);
    check("jump.last_bad", 32'(bus.last_bad), 32'd7);
    check("jump.good", 32'(bus.good_cnt), 32'd4);

    // Three jumps reach FAIL: 0,5,9,2
    restart();
    step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 5); step(1'b1, 1'b0, 9); step(1'b1, 1'b0, 2);
    check("fail.err", 32'(bus.err_cnt), 32'd3);
    check("fail.state", 32'(bus.state), 32'd3);
    check("fail.flag", 32'(bus.fail), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, int'($urandom_range(0, MOD - 1)));
    check("fail.frozen_err", 32'(bus.err_cnt), 32'd3);
    check("fail.frozen_bad", 32'(bus.last_bad), 32'd2);
    step(1'b1, 1'b1, 11);
    check("fail.clr_state", 32'(bus.state), 32'd0);
    check("fail.clr_err", 32'(bus.err_cnt), 32'd0);
    check("fail.clr_flag", 32'(bus.fail), 32'd0);

    // Repeated sample 3,4,4,5
    restart();
    step(1'b1, 1'b0, 3); step(1'b1, 1'b0, 4); step(1'b1, 1'b0, 4); step(1'b1, 1'b0, 5);
    check("hold.good", 32'(bus.good_cnt), 32'd2);
    if (HOLD) begin
      check("hold.err", 32'(bus.err_cnt), 32'd0);
    end else begin
      check("hold.err", 32'(bus.err_cnt), 32'd1);
      check("hold.last_bad", 32'(bus.last_bad), 32'd4);
    end

    // clr together with a mismatch: clear wins
    restart();
    step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 9);
    check("clrmis.err", 32'(bus.err_cnt), 32'd0);

    // en low holds, then async reset mid-cycle with good_cnt=6
    restart();
    for (int i = 0; i <= 6; i++) step(1'b1, 1'b0, i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, int'($urandom_range(0, MOD - 1)));
    check("enlow.good", 32'(bus.good_cnt), 32'd6);
    check("enlow.state", 32'(bus.state), 32'd2);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.good", 32'(bus.good_cnt), 32'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i);
    check("post_rst.state", 32'(bus.state), 32'd0);

    // Randomized traffic: mostly stepping, some stalls, jumps, gaps and clears
    prev_d = 0;
    for (int n = 0; n < 400; n++) begin
      int dv;
      r = int'($urandom_range(0, 99));
      if (r < 70)      dv = (prev_d + STEP) % MOD;
      else if (r < 82) dv = prev_d;
      else             dv = int'($urandom_range(0, MOD - 1));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, dv);
      prev_d = dv;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
